// File: rtl/instr_fetch_unit.sv
// LEGv8 instruction fetch front end: PC, single-outstanding imem requests, prefetch FIFO.
// Optional IFU_PERF_CNT_EN adds perf_fetched / perf_flushed counters.
module instr_fetch_unit #(
    parameter int unsigned         ADDR_W     = 64,
    parameter logic [ADDR_W-1:0]   RESET_PC   = '0,
    parameter int unsigned         FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [10:0]       out_opcode,
    output logic [ADDR_W-1:0] out_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_flushed
`endif
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] fetch_pc, drop_addr;
    logic [ADDR_W-1:0] buf_pc    [FIFO_DEPTH];
    logic [31:0]       buf_instr [FIFO_DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count, count_after;
    logic              push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign out_valid   = (count != '0);
    assign pop         = out_valid && out_ready && !redirect_valid;
    assign push        = (state == REQ) && imem_ack && !redirect_valid;
    assign count_after = count + CW'(push) - CW'(pop);

    assign imem_req   = (state != IDLE);
    // A squashed request keeps presenting its original address until it completes
    assign imem_addr  = (state == DROP) ? drop_addr : fetch_pc;
    assign out_instr  = out_valid ? buf_instr[rd_ptr] : '0;
    assign out_pc     = out_valid ? buf_pc[rd_ptr]    : '0;
    assign out_opcode = out_instr[31:21];

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (count < CW'(FIFO_DEPTH)) state_n = REQ;
            REQ:  if (imem_ack) state_n = (count_after < CW'(FIFO_DEPTH)) ? REQ : IDLE;
            DROP: if (imem_ack) state_n = REQ;
            default: state_n = IDLE;
        endcase
        // Redirect overrides; an outstanding request without ack must be drained first
        if (redirect_valid) begin
            unique case (state)
                IDLE:    state_n = REQ;
                REQ:     state_n = imem_ack ? REQ : DROP;
                DROP:    state_n = imem_ack ? REQ : DROP;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            drop_addr <= RESET_PC;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                buf_pc[i]    <= '0;
                buf_instr[i] <= '0;
            end
        end else begin
            state <= state_n;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                if (state == REQ && !imem_ack) drop_addr <= fetch_pc;
            end else begin
                if (push) begin
                    buf_pc[wr_ptr]    <= fetch_pc;
                    buf_instr[wr_ptr] <= imem_rdata;
                    wr_ptr            <= ptr_inc(wr_ptr);
                    fetch_pc          <= fetch_pc + ADDR_W'(4);
                end
                if (pop) rd_ptr <= ptr_inc(rd_ptr);
                count <= count_after;
            end
        end
    end

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (push) perf_fetched <= perf_fetched + 32'd1;
            if (redirect_valid)
                perf_flushed <= perf_flushed + 32'(count) + 32'(state == REQ && imem_ack);
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a latency-configurable memory model
// feeds the DUT; expected PCs are queued on ack and checked on each pop.
module tb_instr_fetch_unit;

    localparam int unsigned AW    = 64;
    localparam int unsigned DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [10:0]   out_opcode;
    logic [AW-1:0] out_pc;
`ifdef IFU_PERF_CNT_EN
    logic [31:0]   perf_fetched;
    logic [31:0]   perf_flushed;
`endif

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W     (AW),
        .RESET_PC   (64'h0),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_opcode     (out_opcode),
        .out_pc         (out_pc)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed)
`endif
    );

    int            n_cmp = 0;
    int            n_err = 0;
    logic [63:0]   q[$];
    logic [63:0]   exp_fetch;
    bit            drop_pending;
    int unsigned   age, lat, n_push, last_flush;
    bit            rdy;

    function automatic logic [31:0] memword(input logic [63:0] a);
        logic [31:0] lo;
        lo = a[31:0];
        return (lo * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, check/model at negedge+1, then advance.
    task automatic tick(input bit redir, input logic [63:0] tgt);
        logic [63:0] e;
        logic [31:0] w;
        bit          ack;
        ack            = imem_req && (age >= lat);
        imem_ack       = ack;
        imem_rdata     = ack ? memword(imem_addr) : 32'h0;
        out_ready      = rdy;
        redirect_valid = redir;
        redirect_pc    = redir ? tgt : 64'h0;
        #1;
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        if (out_valid && rdy && !redir && q.size() != 0) begin
            e = q.pop_front();
            w = memword(e);
            chk("out_pc", out_pc, e);
            chk("out_instr", 64'(out_instr), 64'(w));
            chk("out_opcode", 64'(out_opcode), 64'(w[31:21]));
        end
        if (ack) begin
            if (drop_pending) drop_pending = 0;
            else if (!redir) begin
                chk("imem_addr", imem_addr, exp_fetch);
                q.push_back(exp_fetch);
                exp_fetch = exp_fetch + 64'd4;
                n_push++;
            end
        end
        if (redir) begin
            last_flush = q.size();
            q.delete();
            exp_fetch = tgt;
            if (imem_req && !ack) drop_pending = 1;
        end
        age = ack ? 0 : (imem_req ? age + 1 : 0);
        @(posedge clk);
        @(negedge clk);
        imem_ack       = 1'b0;
        redirect_valid = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 64'h0);
    endtask

    task automatic do_reset();
        imem_ack       = 1'b0;
        redirect_valid = 1'b0;
        reset          = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        exp_fetch    = 64'h0;
        drop_pending = 0;
        age          = 0;
        n_push       = 0;
        #1;
        chk("rst_req", 64'(imem_req), 64'h0);
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_pc", out_pc, 64'h0);
        chk("rst_instr", 64'(out_instr), 64'h0);
        chk("rst_opcode", 64'(out_opcode), 64'h0);
        @(negedge clk);
    endtask

    logic [63:0] sv_pc, sv_instr, old_addr;
    bit          cond;

    initial begin
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        rdy = 1; lat = 1; age = 0; n_push = 0; last_flush = 0;
        @(negedge clk);

        // Streaming fetch, one-cycle memory latency
        do_reset();
        rdy = 1; lat = 1;
        ticks(30);
        chk("t1_pushes", 64'(n_push >= 10), 64'h1);

        // Back-pressure: FIFO fills, request stops, head holds
        do_reset();
        rdy = 0; lat = 0;
        ticks(10);
        chk("t2_fill", 64'(q.size()), 64'(DEPTH));
        chk("t2_req_low", 64'(imem_req), 64'h0);
        sv_pc = out_pc; sv_instr = 64'(out_instr);
        ticks(3);
        chk("t2_pc_stable", out_pc, sv_pc);
        chk("t2_instr_stable", 64'(out_instr), sv_instr);
        rdy = 1;
        ticks(20);
        chk("t2_resumed", 64'(n_push >= DEPTH + 5), 64'h1);

        // Redirect while a request has been waiting 3 cycles
        do_reset();
        rdy = 1; lat = 5;
        for (int i = 0; i < 50 && !(imem_req && age == 3); i++) tick(1'b0, 64'h0);
        chk("t3_wait", 64'(imem_req && age == 3), 64'h1);
        old_addr = imem_addr;
        tick(1'b1, 64'h100);
        chk("t3_drop_addr", imem_addr, old_addr);
        lat = 1;
        for (int i = 0; i < 50 && !out_valid; i++) tick(1'b0, 64'h0);
        chk("t3_first_pc", out_pc, 64'h100);
        ticks(10);

        // Redirect coinciding with ack and pop on a nearly full FIFO
        do_reset();
        rdy = 0; lat = 3;
        cond = 0;
        for (int i = 0; i < 50 && !cond; i++) begin
            cond = (q.size() == DEPTH - 1) && imem_req && (age >= lat);
            if (!cond) tick(1'b0, 64'h0);
        end
        chk("t4_wait", 64'(cond), 64'h1);
        rdy = 1;
        tick(1'b1, 64'h200);
        chk("t4_empty", 64'(out_valid), 64'h0);
        lat = 1;
        for (int i = 0; i < 50 && !out_valid; i++) tick(1'b0, 64'h0);
        chk("t4_first_pc", out_pc, 64'h200);
        ticks(8);

        // Asynchronous reset mid-request, then address wrap
        do_reset();
        rdy = 1; lat = 6;
        ticks(3);
        #2 reset = 1'b1;
        #1;
        chk("t5_async_req", 64'(imem_req), 64'h0);
        chk("t5_async_valid", 64'(out_valid), 64'h0);
        @(negedge clk);
        do_reset();
        lat = 0;
        ticks(4);
        lat = 1;
        tick(1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
        ticks(20);
        chk("t5_wrapped", 64'(exp_fetch < 64'h100), 64'h1);

`ifdef IFU_PERF_CNT_EN
        do_reset();
        rdy = 1; lat = 0;
        for (int i = 0; i < 100 && n_push < 8; i++) tick(1'b0, 64'h0);
        rdy = 0;
        for (int i = 0; i < 50 && imem_req; i++) tick(1'b0, 64'h0);
        chk("t6_idle", 64'(imem_req), 64'h0);
        chk("t6_fetched", 64'(perf_fetched), 64'(n_push));
        tick(1'b1, 64'h300);
        chk("t6_flushed", 64'(perf_flushed), 64'(last_flush));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
